// File: rtl/run_pkg.sv
// run_pkg: shared state type and default timing constants for the run sequencer
package run_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RSTC, RUN, FIN, TOUT} run_state_t;
  localparam int TIMEOUT_DEF = 4096;
  localparam int RST_CYCLES_DEF = 4;
endpackage

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: cycle counter with clear, enable and terminal-count compare
module run_cycle_ctr #(
  parameter int CW = 16,
  parameter int TERM = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          term
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + CW'(1);
  assign term = count == CW'(TERM);
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: loads data memory, holds the core in reset, runs it until done, timeout or abort
module run_ctrl
  import run_pkg::*;
#(
  parameter int CW = 16,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_last,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic          aborted,
  output logic [CW-1:0] cycle_count,
  output logic [AW:0]   load_count
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  run_state_t state, state_next;
  logic [RW-1:0] rst_cnt;
  logic go, acc, term, run_en;
  assign go = start && (state == IDLE || state == FIN || state == TOUT);
  assign acc = ld_valid && ld_ready;
  assign run_en = state == RUN && state_next == RUN;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN, TOUT: state_next = start ? LOAD : state;
      LOAD: state_next = abort ? IDLE : (acc && ld_last) ? RSTC : LOAD;
      RSTC: state_next = abort ? IDLE : (rst_cnt == '0) ? RUN : RSTC;
      RUN: state_next = abort ? IDLE : core_done ? FIN : term ? TOUT : RUN;
      default: state_next = IDLE;
    endcase
  end
  // ld_ready drops in the abort cycle so no beat is written on the way out
  always_comb begin
    ld_ready = state == LOAD && !abort;
    core_reset = state != RUN;
    core_req = state == RUN && cycle_count == '0;
    busy = state == LOAD || state == RSTC || state == RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rst_cnt <= '0;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_dat <= '0;
      finished <= 1'b0;
      timed_out <= 1'b0;
      aborted <= 1'b0;
      load_count <= '0;
    end else begin
      mem_wr_en <= acc;
      if (acc) begin
        mem_addr <= ld_addr;
        mem_dat <= ld_data;
      end
      if (go) begin
        finished <= 1'b0;
        timed_out <= 1'b0;
        aborted <= 1'b0;
        load_count <= '0;
      end else if (acc && !load_count[AW]) load_count <= load_count + (AW+1)'(1);
      rst_cnt <= (state == RSTC) ? rst_cnt - RW'(1) : RW'(RST_CYCLES - 1);
      if (busy && abort) aborted <= 1'b1;
      if (state_next == FIN) finished <= 1'b1;
      if (state_next == TOUT) timed_out <= 1'b1;
    end
  run_cycle_ctr #(.CW(CW), .TERM(TIMEOUT - 1)) u_ctr (
    .clk(clk), .reset(reset), .clr(go), .en(run_en), .count(cycle_count), .term(term)
  );
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed stimulus against a cycle-level behavioural model plus literal checks
module tb_run_ctrl;
  localparam int TO = 4096;
  localparam int RST = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RSTC = 2, M_RUN = 3, M_FIN = 4, M_TOUT = 5;
  logic clk = 0, reset = 1, start = 0, abort = 0, ld_valid = 0, ld_last = 0, core_done = 0;
  logic [7:0] ld_addr = 0, ld_data = 0;
  logic ld_ready, mem_wr_en, core_reset, core_req, busy, finished, timed_out, aborted;
  logic [7:0] mem_addr, mem_dat;
  logic [15:0] cycle_count;
  logic [8:0] load_count;
  int pass = 0, total = 0, nreq = 0, nrst = 0;
  bit go = 0;
  logic [15:0] wlog[$];
  int md = M_IDLE, cc = 0, lc = 0, rl = 0;
  bit f_fin = 0, f_to = 0, f_ab = 0, e_wr = 0;
  logic [7:0] e_addr = 0, e_dat = 0;

  run_ctrl #(.CW(16), .TIMEOUT(TO), .RST_CYCLES(RST), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_last(ld_last), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat), .core_reset(core_reset),
    .core_req(core_req), .core_done(core_done), .busy(busy), .finished(finished),
    .timed_out(timed_out), .aborted(aborted), .cycle_count(cycle_count), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // model: mode + counters advanced by the written rules, one step per clock
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md = M_IDLE; cc = 0; lc = 0; rl = 0; f_fin = 0; f_to = 0; f_ab = 0;
      e_wr = 0; e_addr = 0; e_dat = 0;
    end else begin
      e_wr = 0;
      if (md == M_IDLE || md == M_FIN || md == M_TOUT) begin
        if (start) begin
          md = M_LOAD; cc = 0; lc = 0; f_fin = 0; f_to = 0; f_ab = 0;
        end
      end else if (abort) begin
        md = M_IDLE; f_ab = 1;
      end else if (md == M_LOAD) begin
        if (ld_valid) begin
          e_wr = 1; e_addr = ld_addr; e_dat = ld_data;
          lc = (lc < 256) ? lc + 1 : 256;
          if (ld_last) begin md = M_RSTC; rl = RST; end
        end
      end else if (md == M_RSTC) begin
        rl--;
        if (rl == 0) md = M_RUN;
      end else if (core_done) begin
        md = M_FIN; f_fin = 1;
      end else if (cc == TO - 1) begin
        md = M_TOUT; f_to = 1;
      end else cc++;
    end
  end

  always @(negedge clk) if (go) begin
    chk("ld_ready", ld_ready, md == M_LOAD && !abort);
    chk("core_reset", core_reset, md != M_RUN);
    chk("core_req", core_req, md == M_RUN && cc == 0);
    chk("busy", busy, md == M_LOAD || md == M_RSTC || md == M_RUN);
    chk("mem_wr_en", mem_wr_en, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_dat", mem_dat, e_dat);
    chk("finished", finished, f_fin);
    chk("timed_out", timed_out, f_to);
    chk("aborted", aborted, f_ab);
    chk("cycle_count", cycle_count, cc);
    chk("load_count", load_count, lc);
  end

  always @(negedge clk) begin
    if (mem_wr_en) wlog.push_back({mem_addr, mem_dat});
    if (core_req) nreq++;
    if (busy && core_reset && !ld_ready) nrst++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1; tick; start = 0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
    tick;
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic wait_req;
    for (int n = 0; n < 50 && !core_req; n++) tick;
    chk("req_seen", core_req, 1);
  endtask

  task automatic finish_with_done(input int n);
    repeat (n) tick;
    core_done = 1; tick; core_done = 0;
  endtask

  initial begin
    logic [15:0] exp_w[3];
    exp_w[0] = 16'h0011; exp_w[1] = 16'h0122; exp_w[2] = 16'h0233;
    repeat (3) tick;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    reset = 0; go = 1;
    tick;
    // 1: three-beat load, reset interval, single req
    wlog.delete(); nreq = 0; nrst = 0;
    pulse_start;
    beat(8'd0, 8'h11, 0); beat(8'd1, 8'h22, 0); beat(8'd2, 8'h33, 1);
    chk("t1_load_count", load_count, 3);
    wait_req;
    chk("t1_rstc_cycles", nrst, 4);
    chk("t1_writes", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t1_wr", wlog[i], exp_w[i]);
    // 2: done after 100 RUN cycles
    finish_with_done(100);
    chk("t1_req_pulses", nreq, 1);
    chk("t2_finished", finished, 1);
    chk("t2_cycles", cycle_count, 100);
    chk("t2_core_reset", core_reset, 1);
    chk("t2_busy", busy, 0);
    // 3: timeout
    pulse_start;
    beat(8'd4, 8'h44, 1);
    wait_req;
    repeat (TO) tick;
    chk("t3_timed_out", timed_out, 1);
    chk("t3_cycles", cycle_count, 16'd4095);
    chk("t3_finished", finished, 0);
    chk("t3_busy", busy, 0);
    // 4: done on the timeout cycle
    pulse_start;
    chk("t4_flags_clear", {finished, timed_out, aborted}, 0);
    beat(8'd5, 8'h55, 1);
    wait_req;
    finish_with_done(TO - 1);
    chk("t4_finished", finished, 1);
    chk("t4_timed_out", timed_out, 0);
    chk("t4_cycles", cycle_count, 16'd4095);
    // 5a: abort in LOAD after one beat, beat offered during abort is dropped
    wlog.delete();
    pulse_start;
    beat(8'd6, 8'h66, 0);
    abort = 1; ld_valid = 1; ld_addr = 8'd7; ld_data = 8'h77; ld_last = 1;
    tick;
    abort = 0; ld_valid = 0; ld_last = 0;
    repeat (2) tick;
    chk("t5a_aborted", aborted, 1);
    chk("t5a_writes", wlog.size(), 1);
    chk("t5a_load_count", load_count, 1);
    chk("t5a_core_reset", core_reset, 1);
    chk("t5a_ld_ready", ld_ready, 0);
    // 5b: abort in RUN cycle 10
    pulse_start;
    chk("t5b_aborted_clear", aborted, 0);
    beat(8'd8, 8'h88, 1);
    wait_req;
    repeat (10) tick;
    abort = 1; tick; abort = 0;
    chk("t5b_aborted", aborted, 1);
    chk("t5b_cycles", cycle_count, 10);
    chk("t5b_busy", busy, 0);
    chk("t5b_core_reset", core_reset, 1);
    chk("t5b_finished", finished, 0);
    // 6: async reset mid-RUN, then restart from FIN
    pulse_start;
    beat(8'd9, 8'h99, 1);
    wait_req;
    repeat (20) tick;
    #1 reset = 1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_core_reset", core_reset, 1);
    chk("t6_rst_cycles", cycle_count, 0);
    chk("t6_rst_load_count", load_count, 0);
    chk("t6_rst_mem", {mem_wr_en, mem_addr, mem_dat}, 0);
    repeat (2) tick;
    reset = 0;
    tick;
    pulse_start;
    beat(8'd10, 8'hAA, 0); beat(8'd11, 8'hBB, 1);
    wait_req;
    finish_with_done(5);
    chk("t6_finished", finished, 1);
    chk("t6_load_count", load_count, 2);
    pulse_start;
    chk("t6_restart_finished", finished, 0);
    chk("t6_restart_load_count", load_count, 0);
    chk("t6_restart_cycles", cycle_count, 0);
    chk("t6_restart_busy", busy, 1);
    tick;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
